coffee_mealy_axil_slave: RTL and testbench
==========================================

# coffee_mealy_axil_slave

AXI4-Lite slave that fronts the coffee vending Mealy machine with a four-register map at offsets 0x00–0x0C. Software drives the machine by writing coin codes and reads back credit, change, vend flags and a cup counter. The block sits behind the interconnect as the responder to the PS/VIP master. It contains the bus handshake logic, the register file and the vending FSM.

## Interface
- PRICE, 35: cup price in cents; legal range 5..200, multiple of 5.
- CNT_W, 16: width of the cups-dispensed counter.
- clock  in  1  single system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- s_axi_awaddr  in  4  write address; bits [1:0] are ignored.
- s_axi_awvalid / s_axi_awready  in / out  1  write-address handshake.
- s_axi_wdata  in  32  write data.
- s_axi_wstrb  in  4  byte strobes; only wstrb[0] is honoured (all fields are in byte 0/1, see Operation).
- s_axi_wvalid / s_axi_wready  in / out  1  write-data handshake.
- s_axi_bresp  out  2  OKAY=00, SLVERR=10.
- s_axi_bvalid / s_axi_bready  out / in  1  write-response handshake.
- s_axi_araddr  in  4  read address.
- s_axi_arvalid / s_axi_arready  in / out  1  read-address handshake.
- s_axi_rdata  out  32  read data.
- s_axi_rresp  out  2  always OKAY.
- s_axi_rvalid / s_axi_rready  out / in  1  read-data handshake.
- irq  out  1  vend interrupt; present only under COFFEE_MEALY_IRQ_EN.

## Operation
- **Register map.**
  - 0x00 CTRL (RW).
    - bit0 enable.
    - bit1 refund; self-clearing pulse, reads as 0.
    - bit2 clr_cnt; self-clearing pulse, reads as 0.
  - 0x04 COIN (RW).
    - A write of bits [1:0] issues a coin event. Codes: 1=5c, 2=10c, 3=25c, 0=invalid.
    - A read returns the last written code.
  - 0x08 STATUS (RO).
    - [7:0] credit.
    - [15:8] last change.
    - bit16 vend, sticky.
    - bit17 bad_coin, sticky.
    - bit18 busy (state==COLLECT).
    - A read of STATUS clears bits 16–17.
  - 0x0C CUPS (RO): [CNT_W-1:0] cups dispensed, saturating at all-ones.
- **Writes.** A write to 0x08 or 0x0C is discarded and returns bresp=SLVERR. All other writes return OKAY.
- **FSM states:** IDLE (credit==0) and COLLECT (0<credit<PRICE). Coin events are ignored while enable==0; such a write still returns OKAY.
- **Valid coin event, value v.** Let sum = credit+v.
  - If sum ≥ PRICE: vend (Mealy output on the transition).
    - change ← sum−PRICE, credit ← 0, state → IDLE.
    - vend sticky ← 1; CUPS increments.
  - Otherwise: credit ← sum, state → COLLECT. The change field is unchanged.
- **Invalid coin (code 0).** bad_coin ← 1. Credit and state are unchanged.
- **Refund.** change ← credit, credit ← 0, state → IDLE. There is no vend. A refund in IDLE gives change ← 0.
- **clr_cnt.** CUPS ← 0. If a vend occurs in the same cycle, the clear wins.
- **Arithmetic.**
  - credit is 8-bit.
  - sum is computed at 9 bits. The maximum sum is PRICE−5+25, so it never overflows.
  - change fits in 8 bits.

## Timing
- **Reset values.** All ready/valid outputs 0, bresp/rresp/rdata 0, irq 0. All registers 0; state IDLE.
- **Write channel.**
  - awready and wready are independent, each high while its beat has not yet been captured and bvalid==0.
  - AW and W may arrive in either order or together.
  - The write commits on the edge where the second of the two is captured.
  - bvalid rises the next cycle and holds until bready.
  - Only one write is outstanding.
- **Coin and refund timing.** The commit produces a 1-cycle event. The FSM updates on the following edge. STATUS and CUPS show the new value on a read whose AR handshake is ≥2 cycles after the commit.
- **Read channel.**
  - arready is high while rvalid==0.
  - rvalid rises the cycle after the AR handshake, with data sampled at the AR handshake, and holds until rready.
- **Concurrency.**
  - Reads and writes proceed concurrently.
  - A STATUS read sampled in the same cycle as an FSM update returns the pre-update value.
  - A sticky bit set in the same cycle as a STATUS-read clear stays set.
- **Mid-transfer reset.** Reset asserted during a transaction aborts it immediately. No response is issued after release.

## Configuration
- **COFFEE_MEALY_IRQ_EN defined:**
  - The irq port exists.
  - CTRL bit3 is irq_en (RW).
  - irq = vend sticky & irq_en, registered; it rises 1 cycle after the vend edge.
  - irq is cleared via the STATUS read.
- **COFFEE_MEALY_IRQ_EN not defined:**
  - There is no irq port.
  - CTRL bit3 reads 0 and ignores writes.

## Structure
- **coffee_mealy_pkg** holds:
  - register offset localparams (CTRL/COIN/STATUS/CUPS);
  - the coin_e enum;
  - the state_e enum {IDLE, COLLECT};
  - RESP_OKAY/RESP_SLVERR;
  - a coin-value function.
- **coffee_mealy_fsm** sub-module: vending FSM, credit, change and CUPS logic.
  - Inputs: the event pulses.
  - Outputs: status fields.
- The bus handshake and the register file stay in the top level.

## Test plan
- Reset, then read all four registers: all read 0x00000000 with rresp OKAY.
- CTRL=1, then write COIN 3 and COIN 2 (PRICE=35): STATUS reads vend=1, change=0, credit=0; CUPS=1. A second STATUS read returns vend=0.
- Write COIN 3 twice: the first leaves credit=25 and busy=1. The second vends with change=15.
- Credit 10 then refund: STATUS change=10, credit=0; CUPS is unchanged.
- Write to 0x0C: bresp=SLVERR and CUPS is unchanged.
- Handshake ordering:
  - AW 3 cycles before W: exactly one B with OKAY.
  - W before AW: exactly one B with OKAY.
  - bready held low 5 cycles: bvalid stays high and no second write is accepted.

Source files
------------

// File: rtl/coffee_mealy_pkg.sv
// Shared definitions for the coffee vending AXI4-Lite slave: register offsets,
// response codes, coin/state enums and the coin-value helper.
package coffee_mealy_pkg;

  localparam logic [3:0] REG_CTRL   = 4'h0;
  localparam logic [3:0] REG_COIN   = 4'h4;
  localparam logic [3:0] REG_STATUS = 4'h8;
  localparam logic [3:0] REG_CUPS   = 4'hC;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    COIN_BAD = 2'd0,
    COIN_5   = 2'd1,
    COIN_10  = 2'd2,
    COIN_25  = 2'd3
  } coin_e;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_e;

  function automatic logic [8:0] coin_value(coin_e c);
    case (c)
      COIN_5:  return 9'd5;
      COIN_10: return 9'd10;
      COIN_25: return 9'd25;
      default: return 9'd0;
    endcase
  endfunction

endpackage

// File: rtl/coffee_mealy_fsm.sv
// Vending Mealy machine: credit accumulation, vend/change on the transition,
// sticky status flags and the saturating cups-dispensed counter.
module coffee_mealy_fsm
  import coffee_mealy_pkg::*;
#(
  parameter int PRICE = 35,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             coin_evt,
  input  logic [1:0]       coin_code,
  input  logic             refund_evt,
  input  logic             clr_evt,
  input  logic             sticky_clr,
  output logic [7:0]       credit,
  output logic [7:0]       change,
  output logic             vend_sticky,
  output logic             bad_sticky,
  output logic             busy,
  output logic [CNT_W-1:0] cups
);

  // state   | meaning
  // IDLE    | no credit held (credit == 0)
  // COLLECT | partial payment held (0 < credit < PRICE)

  localparam logic [8:0] PRICE9 = 9'(PRICE);

  state_e     state;
  logic [8:0] sum;
  logic [8:0] over;
  logic       coin_ok;
  logic       vend_now;
  logic       unused_over;

  assign sum         = {1'b0, credit} + coin_value(coin_e'(coin_code));
  assign over        = sum - PRICE9;
  assign coin_ok     = coin_evt && (coin_e'(coin_code) != COIN_BAD);
  assign vend_now    = coin_ok && (sum >= PRICE9);
  assign busy        = (state == COLLECT);
  assign unused_over = over[8];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      credit      <= '0;
      change      <= '0;
      vend_sticky <= 1'b0;
      bad_sticky  <= 1'b0;
      cups        <= '0;
    end else begin
      // Clear first so a flag raised on the same edge survives.
      if (sticky_clr) begin
        vend_sticky <= 1'b0;
        bad_sticky  <= 1'b0;
      end
      if (coin_evt) begin
        if (!coin_ok) begin
          bad_sticky <= 1'b1;
        end else if (vend_now) begin
          change      <= over[7:0];
          credit      <= '0;
          state       <= IDLE;
          vend_sticky <= 1'b1;
        end else begin
          credit <= sum[7:0];
          state  <= COLLECT;
        end
      end else if (refund_evt) begin
        change <= credit;
        credit <= '0;
        state  <= IDLE;
      end
      if (clr_evt) begin
        cups <= '0;
      end else if (vend_now && (cups != '1)) begin
        cups <= cups + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/coffee_mealy_axil_slave.sv
// AXI4-Lite front end and register file for the coffee vending machine.
// Optional vend interrupt (port irq, CTRL bit3 irq_en) under COFFEE_MEALY_IRQ_EN.
module coffee_mealy_axil_slave
  import coffee_mealy_pkg::*;
#(
  parameter int PRICE = 35,
  parameter int CNT_W = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [3:0]  s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready
`ifdef COFFEE_MEALY_IRQ_EN
  ,
  output logic        irq
`endif
);

  logic             ready_en;
  logic             aw_done;
  logic             w_done;
  logic [3:0]       awaddr_q;
  logic [31:0]      wdata_q;
  logic [3:0]       wstrb_q;
  logic             aw_hs;
  logic             w_hs;
  logic             ar_hs;
  logic             commit;
  logic [3:0]       wr_addr;
  logic [31:0]      wr_data;
  logic [3:0]       wr_strb;
  logic [3:0]       wr_reg;
  logic [3:0]       rd_reg;
  logic             wr_ro;
  logic [31:0]      rd_mux;

  logic             enable;
  logic             irq_en_bit;
  logic [1:0]       coin_q;
  logic             coin_evt;
  logic             refund_evt;
  logic             clr_evt;
  logic             sticky_clr;

  logic [7:0]       credit;
  logic [7:0]       change;
  logic             vend_sticky;
  logic             bad_sticky;
  logic             busy;
  logic [CNT_W-1:0] cups;
  logic             unused_bits;

  // Readies are held off during reset and for the first cycle after it.
  assign s_axi_awready = ready_en && !aw_done && !s_axi_bvalid;
  assign s_axi_wready  = ready_en && !w_done && !s_axi_bvalid;
  assign s_axi_arready = ready_en && !s_axi_rvalid;
  assign s_axi_rresp   = RESP_OKAY;

  assign aw_hs   = s_axi_awvalid && s_axi_awready;
  assign w_hs    = s_axi_wvalid && s_axi_wready;
  assign ar_hs   = s_axi_arvalid && s_axi_arready;
  assign commit  = (aw_done || aw_hs) && (w_done || w_hs) && (aw_hs || w_hs);
  assign wr_addr = aw_hs ? s_axi_awaddr : awaddr_q;
  assign wr_data = w_hs ? s_axi_wdata : wdata_q;
  assign wr_strb = w_hs ? s_axi_wstrb : wstrb_q;
  assign wr_reg  = {wr_addr[3:2], 2'b00};
  assign rd_reg  = {s_axi_araddr[3:2], 2'b00};
  assign wr_ro   = (wr_reg == REG_STATUS) || (wr_reg == REG_CUPS);

  assign sticky_clr = ar_hs && (rd_reg == REG_STATUS);

  always_comb begin
    rd_mux = '0;
    case (rd_reg)
      REG_CTRL:   rd_mux = {28'd0, irq_en_bit, 2'b00, enable};
      REG_COIN:   rd_mux = {30'd0, coin_q};
      REG_STATUS: rd_mux = {13'd0, busy, bad_sticky, vend_sticky, change, credit};
      REG_CUPS:   rd_mux[CNT_W-1:0] = cups;
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ready_en     <= 1'b0;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      awaddr_q     <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= RESP_OKAY;
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
      enable       <= 1'b0;
      coin_q       <= '0;
      coin_evt     <= 1'b0;
      refund_evt   <= 1'b0;
      clr_evt      <= 1'b0;
    end else begin
      ready_en   <= 1'b1;
      coin_evt   <= 1'b0;
      refund_evt <= 1'b0;
      clr_evt    <= 1'b0;
      if (aw_hs) begin
        aw_done  <= 1'b1;
        awaddr_q <= s_axi_awaddr;
      end
      if (w_hs) begin
        w_done  <= 1'b1;
        wdata_q <= s_axi_wdata;
        wstrb_q <= s_axi_wstrb;
      end
      if (commit) begin
        aw_done      <= 1'b0;
        w_done       <= 1'b0;
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= wr_ro ? RESP_SLVERR : RESP_OKAY;
        if (!wr_ro && wr_strb[0]) begin
          if (wr_reg == REG_CTRL) begin
            enable     <= wr_data[0];
            refund_evt <= wr_data[1];
            clr_evt    <= wr_data[2];
          end else begin
            coin_q   <= wr_data[1:0];
            coin_evt <= enable;
          end
        end
      end else if (s_axi_bvalid && s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
      end
      if (ar_hs) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= rd_mux;
      end else if (s_axi_rvalid && s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end
    end
  end

`ifdef COFFEE_MEALY_IRQ_EN
  logic irq_en;
  assign irq_en_bit = irq_en;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (commit && !wr_ro && wr_strb[0] && (wr_reg == REG_CTRL)) begin
        irq_en <= wr_data[3];
      end
      irq <= vend_sticky && irq_en;
    end
  end
`else
  assign irq_en_bit = 1'b0;
`endif

  assign unused_bits = ^{wr_addr[1:0], s_axi_araddr[1:0], wr_data[31:3], wr_strb[3:1]};

  coffee_mealy_fsm #(
    .PRICE(PRICE),
    .CNT_W(CNT_W)
  ) u_fsm (
    .clock      (clock),
    .reset      (reset),
    .coin_evt   (coin_evt),
    .coin_code  (coin_q),
    .refund_evt (refund_evt),
    .clr_evt    (clr_evt),
    .sticky_clr (sticky_clr),
    .credit     (credit),
    .change     (change),
    .vend_sticky(vend_sticky),
    .bad_sticky (bad_sticky),
    .busy       (busy),
    .cups       (cups)
  );

endmodule

// File: tb/tb_coffee_mealy_axil_slave.sv
// Directed bench for coffee_mealy_axil_slave: expected read data and write
// responses are queued at issue time and popped when the DUT responds.
module tb_coffee_mealy_axil_slave;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  s_axi_awaddr = '0;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b0;
  logic [3:0]  s_axi_araddr = '0;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b1;
`ifdef COFFEE_MEALY_IRQ_EN
  logic        irq;
`endif

  always #5 clock = ~clock;

  coffee_mealy_axil_slave #(.PRICE(35), .CNT_W(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .s_axi_awaddr (s_axi_awaddr),
    .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata  (s_axi_wdata),
    .s_axi_wstrb  (s_axi_wstrb),
    .s_axi_wvalid (s_axi_wvalid),
    .s_axi_wready (s_axi_wready),
    .s_axi_bresp  (s_axi_bresp),
    .s_axi_bvalid (s_axi_bvalid),
    .s_axi_bready (s_axi_bready),
    .s_axi_araddr (s_axi_araddr),
    .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rdata  (s_axi_rdata),
    .s_axi_rresp  (s_axi_rresp),
    .s_axi_rvalid (s_axi_rvalid),
    .s_axi_rready (s_axi_rready)
`ifdef COFFEE_MEALY_IRQ_EN
    ,
    .irq          (irq)
`endif
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] rd_q[$];
  logic [1:0]  b_q[$];

  // Reference model of the vending machine (PRICE = 35).
  logic        m_en = 1'b0;
  logic [7:0]  m_credit = '0;
  logic [7:0]  m_change = '0;
  logic        m_vend = 1'b0;
  logic        m_bad = 1'b0;
  logic [15:0] m_cups = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_en = 0; m_credit = 0; m_change = 0; m_vend = 0; m_bad = 0; m_cups = 0;
  endtask

  task automatic m_coin(input logic [1:0] code);
    int v;
    int s;
    if (!m_en) return;
    v = (code == 2'd1) ? 5 : (code == 2'd2) ? 10 : (code == 2'd3) ? 25 : 0;
    if (code == 2'd0) begin
      m_bad = 1;
    end else begin
      s = int'(m_credit) + v;
      if (s >= 35) begin
        m_change = 8'(s - 35);
        m_credit = 0;
        m_vend   = 1;
        if (m_cups != 16'hFFFF) m_cups = m_cups + 16'd1;
      end else begin
        m_credit = 8'(s);
      end
    end
  endtask

  task automatic m_ctrl(input logic [31:0] d);
    m_en = d[0];
    if (d[1]) begin m_change = m_credit; m_credit = 0; end
    if (d[2]) m_cups = 0;
  endtask

  function automatic logic [31:0] m_status();
    return {13'd0, (m_credit != 0), m_bad, m_vend, m_change, m_credit};
  endfunction

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           input logic [1:0] exp_resp, input int bready_dly);
    bit aw_pend = 1;
    bit w_pend  = 1;
    bit aw_take;
    bit w_take;
    int cyc = 0;
    int n;
    int extra = 0;
    logic [1:0] resp;
    b_q.push_back(exp_resp);
    s_axi_awaddr = addr;
    s_axi_wdata  = data;
    s_axi_wstrb  = strb;
    while ((aw_pend || w_pend) && cyc < 40) begin
      s_axi_awvalid = aw_pend && (cyc >= aw_dly);
      s_axi_wvalid  = w_pend && (cyc >= w_dly);
      aw_take = s_axi_awvalid && s_axi_awready;
      w_take  = s_axi_wvalid && s_axi_wready;
      @(posedge clock); #1;
      if (aw_take) aw_pend = 0;
      if (w_take) w_pend = 0;
      cyc++;
    end
    s_axi_awvalid = 0;
    s_axi_wvalid  = 0;
    if (aw_pend || w_pend) check("wr_accept_timeout", 32'(cyc), 32'd0);
    n = 0;
    while (!s_axi_bvalid && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    check("bvalid_seen", 32'(s_axi_bvalid), 32'd1);
    for (int i = 0; i < bready_dly; i++) begin
      @(posedge clock); #1;
      check("bvalid_hold", 32'(s_axi_bvalid), 32'd1);
      check("no_second_wr", {30'd0, s_axi_awready, s_axi_wready}, 32'd0);
    end
    resp = s_axi_bresp;
    s_axi_bready = 1;
    @(posedge clock); #1;
    s_axi_bready = 0;
    check("bresp", 32'(resp), 32'(b_q.pop_front()));
    for (int i = 0; i < 3; i++) begin
      if (s_axi_bvalid) extra++;
      @(posedge clock); #1;
    end
    check("single_b", 32'(extra), 32'd0);
  endtask

  task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp, input string tag);
    int n = 0;
    rd_q.push_back(exp);
    s_axi_araddr  = addr;
    s_axi_arvalid = 1;
    while (!s_axi_arready && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    @(posedge clock); #1;
    s_axi_arvalid = 0;
    n = 0;
    while (!s_axi_rvalid && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    check({tag, "_rvalid"}, 32'(s_axi_rvalid), 32'd1);
    check(tag, s_axi_rdata, rd_q.pop_front());
    check({tag, "_rresp"}, 32'(s_axi_rresp), 32'd0);
    @(posedge clock); #1;
  endtask

  task automatic wr_ctrl(input logic [31:0] d);
    axi_write(4'h0, d, 4'h1, 0, 0, 2'b00, 0);
    m_ctrl(d);
  endtask

  task automatic wr_coin(input logic [1:0] c, input int aw_dly, input int w_dly, input int bdly);
    axi_write(4'h4, {30'd0, c}, 4'h1, aw_dly, w_dly, 2'b00, bdly);
    m_coin(c);
  endtask

  task automatic rd_status(input string tag);
    axi_read(4'h8, m_status(), tag);
    m_vend = 0;
    m_bad  = 0;
  endtask

  initial begin
    int cnt;
    repeat (3) @(posedge clock);
    #1;
    check("rst_readies", {29'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'd0);
    check("rst_valids", {30'd0, s_axi_bvalid, s_axi_rvalid}, 32'd0);
    check("rst_rdata", s_axi_rdata, 32'd0);
    reset = 0;
    @(posedge clock); #1;
    @(posedge clock); #1;

    axi_read(4'h0, 32'd0, "rst_ctrl");
    axi_read(4'h4, 32'd0, "rst_coin");
    axi_read(4'h8, 32'd0, "rst_status");
    axi_read(4'hC, 32'd0, "rst_cups");

    // Coin while disabled: accepted on the bus, no effect on the machine.
    wr_coin(2'd3, 0, 0, 0);
    rd_status("dis_status");
    axi_read(4'h4, 32'd3, "coin_readback");

    wr_ctrl(32'd1);
    axi_read(4'h0, 32'd1, "ctrl_en");
    wr_coin(2'd3, 0, 0, 0);
    wr_coin(2'd2, 0, 0, 0);
    rd_status("vend_exact");
    axi_read(4'hC, 32'(m_cups), "cups_1");
    rd_status("vend_cleared");

    wr_coin(2'd3, 0, 0, 0);
    rd_status("credit_25");
    wr_coin(2'd3, 0, 0, 0);
    rd_status("vend_change15");

    wr_coin(2'd2, 0, 0, 0);
    wr_ctrl(32'd3);
    rd_status("refund_10");
    axi_read(4'hC, 32'(m_cups), "cups_after_refund");
    axi_read(4'h0, 32'd1, "ctrl_pulse_reads0");

    wr_coin(2'd0, 0, 0, 0);
    rd_status("bad_coin");

    axi_write(4'hC, 32'h0000_00FF, 4'hF, 0, 0, 2'b10, 0);
    axi_read(4'hC, 32'(m_cups), "cups_ro");
    axi_write(4'h8, 32'hFFFF_FFFF, 4'hF, 0, 0, 2'b10, 0);
    rd_status("status_ro");

    wr_coin(2'd1, 0, 3, 0);
    wr_coin(2'd1, 3, 0, 0);
    rd_status("credit_10_orders");
    wr_coin(2'd3, 0, 0, 5);
    rd_status("vend_bready_late");
    axi_read(4'hC, 32'(m_cups), "cups_3");

    axi_write(4'h0, 32'd0, 4'h0, 0, 0, 2'b00, 0);
    axi_read(4'h0, 32'd1, "ctrl_nostrb");

    wr_ctrl(32'd3);
    rd_status("refund_idle");
    wr_ctrl(32'd5);
    axi_read(4'hC, 32'(m_cups), "cups_clr");

    // Abort a write mid-transfer: AW captured, then reset.
    s_axi_awaddr  = 4'h4;
    s_axi_awvalid = 1;
    @(posedge clock); #1;
    s_axi_awvalid = 0;
    reset = 1;
    m_reset();
    @(posedge clock); #1;
    reset = 0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (s_axi_bvalid) cnt++;
      @(posedge clock); #1;
    end
    check("abort_no_b", 32'(cnt), 32'd0);
    axi_read(4'h0, 32'd0, "abort_ctrl");
    wr_coin(2'd3, 0, 0, 0);
    rd_status("abort_status");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
